// File: rtl/fetch_unit_pkg.sv
// Shared types, constants and helpers for the instruction-fetch stage.
// Instruction words are 32 bits wide; fetch addresses are 16-bit byte addresses.
package fetch_unit_pkg;
  localparam int PC_W   = 16;
  localparam int WORD_W = 32;

  typedef logic [PC_W-1:0]   pc_bus_t;
  typedef logic [WORD_W-1:0] word_bus_t;

  localparam pc_bus_t PC_STEP          = 16'd4;
  localparam pc_bus_t RESET_PC_DEFAULT = 16'h0000;

  typedef struct packed {
    pc_bus_t   pc;
    word_bus_t inst;
  } fetch_entry_t;

  function automatic pc_bus_t align_word(input pc_bus_t addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

  function automatic int ring_next(input int ptr, input int depth);
    return (ptr == depth - 32'sd1) ? 32'sd0 : ptr + 32'sd1;
  endfunction
endpackage

// File: rtl/fetch_unit_fifo.sv
// Instruction buffer: synchronous FIFO of {pc, inst} entries with flush.
// The head entry is read straight from storage, so decode outputs come from registers.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);
  fetch_entry_t  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          pop_s;

  assign pop_s = pop && !empty;
  assign rdata = mem_r[rd_ptr_r];
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == '0);
  assign count = count_r;

  // Storage and pointers; a flush empties the queue but leaves stale words in place
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= AW'(ring_next(int'(wr_ptr_r), DEPTH));
      end
      if (pop_s) begin
        rd_ptr_r <= AW'(ring_next(int'(rd_ptr_r), DEPTH));
      end
      count_r <= count_r + CW'(push) - CW'(pop_s);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues credit-limited word fetches,
// buffers in-order responses for decode and discards stale responses after a redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter pc_bus_t RESET_PC = RESET_PC_DEFAULT,
  parameter int      DEPTH    = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      pc_sel_i,
  input  pc_bus_t   br_addr_i,
  output logic      imem_req_o,
  output pc_bus_t   imem_addr_o,
  input  logic      imem_gnt_i,
  input  logic      imem_rvalid_i,
  input  word_bus_t imem_rdata_i,
  output logic      id_valid_o,
  input  logic      id_ready_i,
  output pc_bus_t   id_pc_o,
  output word_bus_t id_inst_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  pc_bus_t       fetch_pc_r;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] drop_cnt_r;
  pc_bus_t       shadow_r [DEPTH];
  logic [AW-1:0] sh_wr_r;
  logic [AW-1:0] sh_rd_r;

  logic [CW-1:0] outstanding_next_s;
  logic [CW-1:0] fifo_count_s;
  logic [CW:0]   credit_used_s;
  logic          grant_s;
  logic          rsp_s;
  logic          drop_s;
  logic          push_s;
  logic          pop_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  fetch_entry_t  fifo_wdata_s;
  fetch_entry_t  fifo_rdata_s;

  assign grant_s    = imem_req_o && imem_gnt_i;
  // A response with nothing owed belongs to a fetch issued before reset
  assign rsp_s      = imem_rvalid_i && (outstanding_r != '0);
  assign drop_s     = (drop_cnt_r != '0);
  assign id_valid_o = !fifo_empty_s && !pc_sel_i;
  assign pop_s      = id_valid_o && id_ready_i;
  assign push_s     = rsp_s && !drop_s && !pc_sel_i && (!fifo_full_s || pop_s);

  // A pop in this cycle frees its slot immediately, so a drained buffer keeps streaming
  assign credit_used_s = {1'b0, outstanding_r} + {1'b0, fifo_count_s} - (CW+1)'(pop_s);
  assign imem_req_o    = !rst && (credit_used_s < (CW+1)'(DEPTH));
  assign imem_addr_o   = fetch_pc_r;

  assign outstanding_next_s = outstanding_r + CW'(grant_s) - CW'(rsp_s);

  assign fifo_wdata_s = '{pc: shadow_r[sh_rd_r], inst: imem_rdata_i};
  assign id_pc_o      = fifo_rdata_s.pc;
  assign id_inst_o    = fifo_rdata_s.inst;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (pc_sel_i),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (fifo_wdata_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Fetch PC, in-flight accounting, granted-address shadow queue and drop count
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r    <= RESET_PC;
      outstanding_r <= '0;
      drop_cnt_r    <= '0;
      sh_wr_r       <= '0;
      sh_rd_r       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        shadow_r[i] <= '0;
      end
    end else begin
      outstanding_r <= outstanding_next_s;
      if (grant_s) begin
        shadow_r[sh_wr_r] <= fetch_pc_r;
        sh_wr_r           <= AW'(ring_next(int'(sh_wr_r), DEPTH));
      end
      if (rsp_s) begin
        sh_rd_r <= AW'(ring_next(int'(sh_rd_r), DEPTH));
      end
      // Every response still owed after a redirect is stale, including pending drops
      if (pc_sel_i) begin
        fetch_pc_r <= align_word(br_addr_i);
        drop_cnt_r <= outstanding_next_s;
      end else begin
        if (grant_s) begin
          fetch_pc_r <= fetch_pc_r + PC_STEP;
        end
        if (rsp_s && drop_s) begin
          drop_cnt_r <= drop_cnt_r - CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed phases push expected fetch addresses and
// decode pc/inst pairs; a memory model and a decode monitor pop and compare them.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  logic      pc_sel_i;
  pc_bus_t   br_addr_i;
  logic      imem_req_o;
  pc_bus_t   imem_addr_o;
  logic      imem_gnt_i;
  logic      imem_rvalid_i;
  word_bus_t imem_rdata_i;
  logic      id_valid_o;
  logic      id_ready_i;
  pc_bus_t   id_pc_o;
  word_bus_t id_inst_o;

  int tests  = 0;
  int fails  = 0;
  int cyc    = 0;
  int lat    = 1;
  int budget = 0;

  typedef struct {
    pc_bus_t addr;
    int      due;
  } mreq_t;

  mreq_t   mq[$];
  pc_bus_t exp_addr_q[$];
  pc_bus_t exp_pc_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  fetch_unit #(.RESET_PC(16'h0000), .DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_sel_i      (pc_sel_i),
    .br_addr_i     (br_addr_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .id_valid_o    (id_valid_o),
    .id_ready_i    (id_ready_i),
    .id_pc_o       (id_pc_o),
    .id_inst_o     (id_inst_o)
  );

  function automatic word_bus_t mem_word(input pc_bus_t a);
    return {~a, a};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_fetch(input pc_bus_t a, input bit delivered);
    exp_addr_q.push_back(a);
    if (delivered) exp_pc_q.push_back(a);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_pc_q.size() > 0 || exp_addr_q.size() > 0 || budget > 0) && k < 80) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (k >= 80) begin
      fails++;
      $display("FAIL %s_drain: %0d decode / %0d fetch entries left, want 0", name,
               exp_pc_q.size(), exp_addr_q.size());
    end
  endtask

  // Memory model: grant while budget lasts, answer in order lat cycles after each grant
  initial begin
    pc_bus_t ea;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        mq.delete();
        imem_rvalid_i = 1'b0;
      end else if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        imem_rvalid_i = 1'b0;
      end
      imem_gnt_i = (budget > 0);
      #1;
      if (!rst && imem_req_o && imem_gnt_i) begin
        budget--;
        mq.push_back('{addr: imem_addr_o, due: cyc + lat});
        tests++;
        if (exp_addr_q.size() == 0) begin
          fails++;
          $display("FAIL fetch_addr: got unexpected request %h, want none", imem_addr_o);
        end else begin
          ea = exp_addr_q.pop_front();
          if (imem_addr_o !== ea) begin
            fails++;
            $display("FAIL fetch_addr: got %h, want %h", imem_addr_o, ea);
          end
        end
      end
    end
  end

  // Decode monitor: every accepted instruction must match the scoreboard head
  initial begin
    pc_bus_t ep;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && id_valid_o && id_ready_i) begin
        tests++;
        if (exp_pc_q.size() == 0) begin
          fails++;
          $display("FAIL decode_pair: got unexpected pc %h inst %h, want none", id_pc_o, id_inst_o);
        end else begin
          ep = exp_pc_q.pop_front();
          if (id_pc_o !== ep || id_inst_o !== mem_word(ep)) begin
            fails++;
            $display("FAIL decode_pair: got pc %h inst %h, want pc %h inst %h",
                     id_pc_o, id_inst_o, ep, mem_word(ep));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    pc_sel_i   = 1'b0;
    br_addr_i  = '0;
    id_ready_i = 1'b1;

    // Reset values
    tick(3);
    #3;
    check("rst_req", imem_req_o, 32'd0);
    check("rst_valid", id_valid_o, 32'd0);
    check("rst_addr", imem_addr_o, 32'h0000);
    check("rst_id_pc", id_pc_o, 32'h0000);
    check("rst_id_inst", id_inst_o, 32'h0);

    // Stream from RESET_PC with single-cycle responses
    tick(1);
    rst = 1'b0;
    budget = 6;
    for (int i = 0; i < 6; i++) expect_fetch(pc_bus_t'(16'h0000 + 16'(i * 4)), 1'b1);
    #3;
    check("first_req", imem_req_o, 32'd1);
    check("valid_c0", id_valid_o, 32'd0);
    tick(1); #3;
    check("valid_c1", id_valid_o, 32'd0);
    tick(1); #3;
    check("valid_c2", id_valid_o, 32'd1);
    drain("stream");

    // Decode stall: two grants, then no requests until decode resumes
    id_ready_i = 1'b0;
    budget = 5;
    for (int i = 0; i < 5; i++) expect_fetch(pc_bus_t'(16'h0018 + 16'(i * 4)), 1'b1);
    tick(4);
    for (int i = 0; i < 4; i++) begin
      #3;
      check("stall_req_low", imem_req_o, 32'd0);
      tick(1);
    end
    #3;
    check("stall_head_pc", id_pc_o, 32'h0018);
    check("stall_valid", id_valid_o, 32'd1);
    tick(1);
    id_ready_i = 1'b1;
    drain("stall");

    // Redirect with two fetches in flight
    lat = 3;
    budget = 2;
    expect_fetch(16'h002C, 1'b0);
    expect_fetch(16'h0030, 1'b0);
    for (int i = 0; i < 3; i++) expect_fetch(pc_bus_t'(16'h0100 + 16'(i * 4)), 1'b1);
    tick(2);
    pc_sel_i = 1'b1;
    br_addr_i = 16'h0100;
    budget = 3;
    #3;
    check("redir_valid_low", id_valid_o, 32'd0);
    check("redir_req_low", imem_req_o, 32'd0);
    tick(1);
    pc_sel_i = 1'b0;
    #3;
    check("redir_drop_cnt", dut.drop_cnt_r, 32'd2);
    check("redir_next_addr", imem_addr_o, 32'h0100);
    drain("redirect");

    // Back-to-back redirects with slow responses
    budget = 2;
    expect_fetch(16'h010C, 1'b0);
    expect_fetch(16'h0110, 1'b0);
    for (int i = 0; i < 3; i++) expect_fetch(pc_bus_t'(16'h0300 + 16'(i * 4)), 1'b1);
    tick(2);
    pc_sel_i = 1'b1;
    br_addr_i = 16'h0200;
    budget = 3;
    tick(1);
    br_addr_i = 16'h0300;
    tick(1);
    pc_sel_i = 1'b0;
    #3;
    check("b2b_drop_cnt", dut.drop_cnt_r, 32'd1);
    check("b2b_addr", imem_addr_o, 32'h0300);
    drain("b2b");
    check("b2b_drop_zero", dut.drop_cnt_r, 32'd0);

    // Redirect coinciding with a grant and a response; misaligned target
    lat = 1;
    budget = 4;
    expect_fetch(16'h030C, 1'b0);
    expect_fetch(16'h0310, 1'b0);
    expect_fetch(16'h0100, 1'b1);
    expect_fetch(16'h0104, 1'b1);
    tick(1);
    pc_sel_i = 1'b1;
    br_addr_i = 16'h0102;
    #3;
    check("simul_req", imem_req_o, 32'd1);
    check("simul_valid_low", id_valid_o, 32'd0);
    tick(1);
    pc_sel_i = 1'b0;
    #3;
    check("simul_drop_cnt", dut.drop_cnt_r, 32'd1);
    check("misalign_addr", imem_addr_o, 32'h0100);
    drain("simul");

    // Fetch PC wrap
    pc_sel_i = 1'b1;
    br_addr_i = 16'hFFF8;
    tick(1);
    pc_sel_i = 1'b0;
    budget = 3;
    expect_fetch(16'hFFF8, 1'b1);
    expect_fetch(16'hFFFC, 1'b1);
    expect_fetch(16'h0000, 1'b1);
    drain("wrap");

    // Mid-stream reset
    budget = 10;
    expect_fetch(16'h0004, 1'b1);
    expect_fetch(16'h0008, 1'b0);
    expect_fetch(16'h000C, 1'b0);
    tick(3);
    rst = 1'b1;
    id_ready_i = 1'b0;
    budget = 0;
    tick(1); #3;
    check("mid_rst_req", imem_req_o, 32'd0);
    check("mid_rst_valid", id_valid_o, 32'd0);
    check("mid_rst_addr", imem_addr_o, 32'h0000);
    check("mid_rst_id_pc", id_pc_o, 32'h0000);
    check("mid_rst_id_inst", id_inst_o, 32'h0);
    check("mid_rst_drop", dut.drop_cnt_r, 32'd0);
    tick(1);
    rst = 1'b0;
    id_ready_i = 1'b1;
    budget = 2;
    expect_fetch(16'h0000, 1'b1);
    expect_fetch(16'h0004, 1'b1);
    drain("restart");

    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
